axil_wr_rd_checker: RTL and testbench

Synthesizable AXI4-Lite master that replaces the simulation BFM in front of the `myip` register slave: on `start` it writes a fixed set of test vectors to consecutive slave registers, reads each one back, and checks response codes and data. It sits directly upstream of the slave's S00_AXI port and reports `done`/`error` status for bring-up on hardware and for self-checking benches.

---
 rtl/axil_wr_rd_checker_if.sv | 43 ++++
 rtl/axil_wr_rd_checker.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_axil_wr_rd_checker.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_wr_rd_checker_if.sv
// AXI4-Lite bus bundle between the write/read checker (master) and the register slave.
// VALID may rise without waiting for READY and stays high with stable payload until the
// cycle where VALID and READY are both high; that cycle is the transfer.
interface axil_wr_rd_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_wr_rd_checker.sv
// AXI4-Lite master that writes four fixed vectors to consecutive slave registers, reads each
// back and reports done/error with the failing index and cause. Every output is a flop.
module axil_wr_rd_checker #(
    parameter int                            C_M_AXI_ADDR_WIDTH   = 32,
    parameter int                            C_M_AXI_DATA_WIDTH   = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = '0,
    parameter int                            C_TIMEOUT            = 1024
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_index,
    output logic [2:0]           err_code,
    output logic [2:0]           dbg_state,
    axil_wr_rd_checker_if.master m_axi
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WAIT_B = 3'd2,
        RD     = 3'd3,
        WAIT_R = 3'd4,
        CHECK  = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam logic [2:0]  ERR_NONE    = 3'd0;
    localparam logic [2:0]  ERR_BRESP   = 3'd1;
    localparam logic [2:0]  ERR_RRESP   = 3'd2;
    localparam logic [2:0]  ERR_DATA    = 3'd3;
    localparam logic [2:0]  ERR_TIMEOUT = 3'd4;
    localparam logic [10:0] WAIT_LAST   = 11'(C_TIMEOUT - 1);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    function automatic logic [DW-1:0] vec_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    vec_rom = DW'(32'h0101FFFF);
            2'd1:    vec_rom = DW'(32'hABCD0001);
            2'd2:    vec_rom = DW'(32'hDEAD0011);
            default: vec_rom = DW'(32'hBEEF0011);
        endcase
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [1:0] idx);
        addr_of = C_M_TARGET_BASE_ADDR + {{(AW-4){1'b0}}, idx, 2'b00};
    endfunction

    state_t        r_state;
    logic [1:0]    r_index;
    logic [10:0]   r_wait_cnt;
    logic [AW-1:0] r_awaddr;
    logic          r_awvalid;
    logic [DW-1:0] r_wdata;
    logic          r_wvalid;
    logic          r_bready;
    logic [AW-1:0] r_araddr;
    logic          r_arvalid;
    logic          r_rready;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_rresp;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [1:0]    r_err_index;
    logic [2:0]    r_err_code;

    state_t        w_state_nxt;
    logic [1:0]    w_index_nxt;
    logic [10:0]   w_wait_nxt;
    logic [AW-1:0] w_awaddr_nxt;
    logic          w_awvalid_nxt;
    logic [DW-1:0] w_wdata_nxt;
    logic          w_wvalid_nxt;
    logic          w_bready_nxt;
    logic [AW-1:0] w_araddr_nxt;
    logic          w_arvalid_nxt;
    logic          w_rready_nxt;
    logic [DW-1:0] w_rdata_nxt;
    logic [1:0]    w_rresp_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_error_nxt;
    logic [1:0]    w_err_index_nxt;
    logic [2:0]    w_err_code_nxt;
    logic [2:0]    w_fail_code;
    logic          w_pass;

    logic          w_timeout;
    logic [10:0]   w_wait_inc;
    logic [1:0]    w_index_inc;

    assign w_timeout   = (r_wait_cnt == WAIT_LAST);
    assign w_wait_inc  = r_wait_cnt + 11'd1;
    assign w_index_inc = r_index + 2'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_index_nxt     = r_index;
        w_wait_nxt      = r_wait_cnt;
        w_awaddr_nxt    = r_awaddr;
        w_awvalid_nxt   = r_awvalid;
        w_wdata_nxt     = r_wdata;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_araddr_nxt    = r_araddr;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rdata_nxt     = r_rdata;
        w_rresp_nxt     = r_rresp;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_error_nxt     = r_error;
        w_err_index_nxt = r_err_index;
        w_err_code_nxt  = r_err_code;
        w_fail_code     = ERR_NONE;
        w_pass          = 1'b0;

        case (r_state)
            IDLE, FINISH: begin
                if (start) begin
                    w_done_nxt      = 1'b0;
                    w_error_nxt     = 1'b0;
                    w_err_index_nxt = 2'd0;
                    w_err_code_nxt  = ERR_NONE;
                    w_busy_nxt      = 1'b1;
                    w_index_nxt     = 2'd0;
                    w_awaddr_nxt    = addr_of(2'd0);
                    w_wdata_nxt     = vec_rom(2'd0);
                    w_awvalid_nxt   = 1'b1;
                    w_wvalid_nxt    = 1'b1;
                    w_wait_nxt      = 11'd0;
                    w_state_nxt     = WR;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WR: begin
                // AW and W complete independently; leave once both have gone through.
                if (m_axi.AWREADY) w_awvalid_nxt = 1'b0;
                if (m_axi.WREADY)  w_wvalid_nxt  = 1'b0;
                if ((!r_awvalid || m_axi.AWREADY) && (!r_wvalid || m_axi.WREADY)) begin
                    w_bready_nxt = 1'b1;
                    w_wait_nxt   = 11'd0;
                    w_state_nxt  = WAIT_B;
                end else if (w_timeout) begin
                    w_fail_code = ERR_TIMEOUT;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            WAIT_B: begin
                if (m_axi.BVALID) begin
                    w_bready_nxt = 1'b0;
                    if (m_axi.BRESP != 2'b00) begin
                        w_fail_code = ERR_BRESP;
                    end else begin
                        w_araddr_nxt  = addr_of(r_index);
                        w_arvalid_nxt = 1'b1;
                        w_wait_nxt    = 11'd0;
                        w_state_nxt   = RD;
                    end
                end else if (w_timeout) begin
                    w_fail_code = ERR_TIMEOUT;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            RD: begin
                if (m_axi.ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_wait_nxt    = 11'd0;
                    w_state_nxt   = WAIT_R;
                end else if (w_timeout) begin
                    w_fail_code = ERR_TIMEOUT;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            WAIT_R: begin
                if (m_axi.RVALID) begin
                    w_rready_nxt = 1'b0;
                    w_rdata_nxt  = m_axi.RDATA;
                    w_rresp_nxt  = m_axi.RRESP;
                    w_state_nxt  = CHECK;
                end else if (w_timeout) begin
                    w_fail_code = ERR_TIMEOUT;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            CHECK: begin
                if (r_rresp != 2'b00) begin
                    w_fail_code = ERR_RRESP;
                end else if (r_rdata != vec_rom(r_index)) begin
                    w_fail_code = ERR_DATA;
                end else if (r_index == 2'd3) begin
                    w_pass = 1'b1;
                end else begin
                    w_index_nxt   = w_index_inc;
                    w_awaddr_nxt  = addr_of(w_index_inc);
                    w_wdata_nxt   = vec_rom(w_index_inc);
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_wait_nxt    = 11'd0;
                    w_state_nxt   = WR;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_fail_code != ERR_NONE) begin
            w_error_nxt     = 1'b1;
            w_err_index_nxt = r_index;
            w_err_code_nxt  = w_fail_code;
        end

        // A timeout drops any VALID still outstanding; the slave sees an abandoned request.
        if ((w_fail_code != ERR_NONE) || w_pass) begin
            w_done_nxt    = 1'b1;
            w_busy_nxt    = 1'b0;
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
            w_bready_nxt  = 1'b0;
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b0;
            w_state_nxt   = FINISH;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= IDLE;
            r_index     <= 2'd0;
            r_wait_cnt  <= 11'd0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= 2'd0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_araddr    <= w_araddr_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rdata     <= w_rdata_nxt;
            r_rresp     <= w_rresp_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_err_index <= w_err_index_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    assign m_axi.AWADDR  = r_awaddr;
    assign m_axi.AWPROT  = 3'b000;
    assign m_axi.AWVALID = r_awvalid;
    assign m_axi.WDATA   = r_wdata;
    assign m_axi.WSTRB   = '1;
    assign m_axi.WVALID  = r_wvalid;
    assign m_axi.BREADY  = r_bready;
    assign m_axi.ARADDR  = r_araddr;
    assign m_axi.ARPROT  = 3'b000;
    assign m_axi.ARVALID = r_arvalid;
    assign m_axi.RREADY  = r_rready;

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign err_index = r_err_index;
    assign err_code  = r_err_code;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_axil_wr_rd_checker.sv
// Directed bench for axil_wr_rd_checker: a reactive register slave with fault knobs,
// a write scoreboard with hand-written expected vectors, and per-scenario status checks.
module tb_axil_wr_rd_checker;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [1:0] err_index;
    logic [2:0] err_code, dbg_state;

    axil_wr_rd_checker_if #(.ADDR_W(32), .DATA_W(32)) m_axi ();

    axil_wr_rd_checker #(
        .C_M_AXI_ADDR_WIDTH  (32),
        .C_M_AXI_DATA_WIDTH  (32),
        .C_M_TARGET_BASE_ADDR(32'h0000_0000),
        .C_TIMEOUT           (TIMEOUT)
    ) dut (
        .ACLK     (clk),
        .ARESETN  (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_index(err_index),
        .err_code (err_code),
        .dbg_state(dbg_state),
        .m_axi    (m_axi)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / counters ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] obs_data_q[$];
    logic [31:0] obs_addr_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_delay      = 0;
    int          bresp_err_idx = -1;
    int          corrupt_idx   = -1;
    bit          b_never       = 1'b0;
    int          aw_count      = 0;
    int          ar_count      = 0;
    logic [31:0] mem [4];
    bit          have_aw, have_w, b_pending, r_pending, hs_b, hs_r;
    int          aw_wait, cap_idx, r_idx;
    logic [31:0] cap_addr, cap_data;
    logic [1:0]  b_resp_next;

    always begin : slave_model
        @(posedge clk);
        if (!rst_n) begin
            have_aw = 0; have_w = 0; b_pending = 0; r_pending = 0;
            hs_b = 0; hs_r = 0; aw_wait = 0;
        end else begin
            hs_b = m_axi.BVALID && m_axi.BREADY;
            hs_r = m_axi.RVALID && m_axi.RREADY;
            if (m_axi.AWVALID && m_axi.AWREADY) begin
                have_aw = 1; cap_addr = m_axi.AWADDR; aw_wait = 0; aw_count++;
            end
            if (m_axi.WVALID && m_axi.WREADY) begin
                have_w = 1; cap_data = m_axi.WDATA;
            end
            if (have_aw && have_w) begin
                cap_idx     = int'(cap_addr[3:2]);
                b_resp_next = (cap_idx == bresp_err_idx) ? 2'b10 : 2'b00;
                if (b_resp_next == 2'b00) mem[cap_idx] = cap_data;
                obs_addr_q.push_back(cap_addr);
                obs_data_q.push_back(cap_data);
                have_aw = 0; have_w = 0; b_pending = 1;
            end
            if (m_axi.ARVALID && m_axi.ARREADY) begin
                ar_count++; r_idx = int'(m_axi.ARADDR[3:2]); r_pending = 1;
            end
        end
        @(negedge clk);
        if (!rst_n) begin
            m_axi.AWREADY = 0; m_axi.WREADY = 0; m_axi.ARREADY = 0;
            m_axi.BVALID = 0; m_axi.BRESP = 2'b00;
            m_axi.RVALID = 0; m_axi.RRESP = 2'b00; m_axi.RDATA = '0;
        end else begin
            if (hs_b) m_axi.BVALID = 0;
            if (b_pending) begin
                if (!b_never) begin m_axi.BVALID = 1; m_axi.BRESP = b_resp_next; end
                b_pending = 0;
            end
            if (hs_r) m_axi.RVALID = 0;
            if (r_pending) begin
                m_axi.RVALID = 1;
                m_axi.RRESP  = 2'b00;
                m_axi.RDATA  = (r_idx == corrupt_idx) ? 32'hDEAD0010 : mem[r_idx];
                r_pending = 0;
            end
            if (m_axi.AWVALID) aw_wait++;
            m_axi.AWREADY = (aw_delay == 0) || (m_axi.AWVALID && aw_wait >= aw_delay);
            m_axi.WREADY  = 1;
            m_axi.ARREADY = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 1;
        while (busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic push_exp(input int n);
        logic [31:0] vecs [4];
        vecs[0] = 32'h0101FFFF; vecs[1] = 32'hABCD0001;
        vecs[2] = 32'hDEAD0011; vecs[3] = 32'hBEEF0011;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(vecs[i]);
            exp_addr_q.push_back(32'(4 * i));
        end
    endtask

    task automatic sb_check(input string tag, input int first);
        int n;
        n = exp_q.size();
        check_eq({tag, "_wr_count"}, 32'(obs_data_q.size() - first), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (first + i < obs_data_q.size()) begin
                check_eq({tag, "_wr_addr"}, obs_addr_q[first + i], exp_addr_q[i]);
                check_eq({tag, "_wr_data"}, obs_data_q[first + i], exp_q[i]);
            end
        end
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int cyc, wr0, ar0, aw0, awv_cycles, bcnt, found;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_status", 32'({busy, done, error, err_index, err_code}), 32'd0);
        check_eq("rst_valids", 32'({m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY,
                                   m_axi.ARVALID, m_axi.RREADY}), 32'd0);
        check_eq("rst_awaddr", m_axi.AWADDR, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // zero-wait slave, full pass
        wr0 = obs_data_q.size(); ar0 = ar_count;
        push_exp(4);
        pulse_start();
        check_eq("t1_busy_n1", 32'(busy), 32'd1);
        check_eq("t1_awvalid_n1", 32'(m_axi.AWVALID), 32'd1);
        check_eq("t1_wvalid_n1", 32'(m_axi.WVALID), 32'd1);
        check_eq("t1_wstrb", 32'(m_axi.WSTRB), 32'hF);
        check_eq("t1_awprot", 32'(m_axi.AWPROT), 32'd0);
        wait_idle(cyc);
        check_eq("t1_latency", 32'(cyc), 32'd21);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_error", 32'(error), 32'd0);
        check_eq("t1_err_code", 32'(err_code), 32'd0);
        check_eq("t1_reads", 32'(ar_count - ar0), 32'd4);
        sb_check("t1", wr0);

        // AWREADY three cycles late, WREADY immediate
        aw_delay = 3;
        repeat (2) @(negedge clk);
        wr0 = obs_data_q.size();
        push_exp(4);
        pulse_start();
        awv_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_axi.AWVALID) begin
                awv_cycles++;
                check_eq("t2_awaddr_stable", m_axi.AWADDR, 32'd0);
            end
            if (i == 1) check_eq("t2_wvalid_drop", 32'(m_axi.WVALID), 32'd0);
            @(negedge clk);
        end
        check_eq("t2_awvalid_cycles", 32'(awv_cycles), 32'd3);
        wait_idle(cyc);
        check_eq("t2_done", 32'(done), 32'd1);
        check_eq("t2_error", 32'(error), 32'd0);
        sb_check("t2", wr0);
        aw_delay = 0;

        // vector 2 reads back corrupted
        corrupt_idx = 2;
        repeat (2) @(negedge clk);
        wr0 = obs_data_q.size(); ar0 = ar_count; aw0 = aw_count;
        push_exp(3);
        pulse_start();
        wait_idle(cyc);
        check_eq("t3_status", 32'({done, error, err_index, err_code}), {26'd0, 1'b1, 1'b1, 2'd2, 3'd3});
        check_eq("t3_reads", 32'(ar_count - ar0), 32'd3);
        check_eq("t3_writes", 32'(aw_count - aw0), 32'd3);
        sb_check("t3", wr0);
        corrupt_idx = -1;

        // SLVERR on the write of vector 1
        bresp_err_idx = 1;
        repeat (2) @(negedge clk);
        wr0 = obs_data_q.size(); ar0 = ar_count;
        push_exp(2);
        pulse_start();
        wait_idle(cyc);
        check_eq("t4_status", 32'({done, error, err_index, err_code}), {26'd0, 1'b1, 1'b1, 2'd1, 3'd1});
        check_eq("t4_reads", 32'(ar_count - ar0), 32'd1);
        sb_check("t4", wr0);
        bresp_err_idx = -1;

        // write response never arrives
        b_never = 1'b1;
        repeat (2) @(negedge clk);
        ar0 = ar_count;
        pulse_start();
        bcnt = 0; cyc = 0;
        while (busy && cyc < 200) begin
            if (m_axi.BREADY) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check_eq("t5_idle_reached", 32'(busy), 32'd0);
        check_eq("t5_waitb_cycles", 32'(bcnt), 32'(TIMEOUT));
        check_eq("t5_status", 32'({done, error, err_index, err_code}), {26'd0, 1'b1, 1'b1, 2'd0, 3'd4});
        check_eq("t5_reads", 32'(ar_count - ar0), 32'd0);
        b_never = 1'b0;

        // reset during WAIT_R of vector 1, then a clean run
        repeat (2) @(negedge clk);
        pulse_start();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (m_axi.RREADY && m_axi.ARADDR == 32'h4) found = 1;
            else @(negedge clk);
        end
        check_eq("t6_reach_wait_r", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_status", 32'({busy, done, error, err_index, err_code}), 32'd0);
        check_eq("t6_rst_valids", 32'({m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY,
                                      m_axi.ARVALID, m_axi.RREADY}), 32'd0);
        check_eq("t6_rst_araddr", m_axi.ARADDR, 32'd0);
        check_eq("t6_rst_wdata", m_axi.WDATA, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wr0 = obs_data_q.size(); ar0 = ar_count;
        push_exp(4);
        pulse_start();
        wait_idle(cyc);
        check_eq("t6_latency", 32'(cyc), 32'd21);
        check_eq("t6_status", 32'({done, error, err_code}), {27'd0, 1'b1, 1'b0, 3'd0});
        check_eq("t6_reads", 32'(ar_count - ar0), 32'd4);
        sb_check("t6", wr0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
